// File: rtl/disp_pkg.sv
// Shared types and helpers for the display-memory arbitration blocks.
// rr_pick is the reference round-robin search used by arbiter_rr_pick.
package disp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int RR_MAX_N = 8;

  // First set bit of req searching upward from last+1 with wrap; returns last if none.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
    logic [2:0] pick;
    logic       found;
    int         p;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      p = (int'(last) + k) % n;
      if (k <= n && !found && req[p[2:0]]) begin
        pick  = p[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arbiter_mem_rr_if.sv
// Requester-side bus of the memory arbiter: per-port req/wr/addr/data in,
// per-port ack and shared read data back.
interface arbiter_mem_rr_if #(
  parameter int N  = 4,
  parameter int AW = 24,
  parameter int DW = 16
);
  logic [N-1:0]         req;
  logic [N-1:0]         wr;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] data;
  logic [N-1:0]         ack;
  logic [DW-1:0]        rdata;

  modport master (output req, wr, addr, data, input ack, rdata);
  modport slave  (input req, wr, addr, data, output ack, rdata);
endinterface

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first requesting
// port after the last granted index, wrapping around.
module arbiter_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  import disp_pkg::*;

  logic [RR_MAX_N-1:0] req_pad;
  logic [2:0]          last_pad;
  logic [2:0]          pick;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
  end

  assign last_pad = 3'(last);
  assign pick     = rr_pick(req_pad, last_pad, N);
  assign valid    = |req;
  assign idx      = IW'(pick);

endmodule

// File: rtl/arbiter_mem_rr.sv
// Shares one memory port among N requesters: round-robin with an optional
// starvation-bounded high-priority port 0, one registered request in flight.
module arbiter_mem_rr #(
  parameter  int N      = 4,
  parameter  int AW     = 24,
  parameter  int DW     = 16,
  parameter  int HP_EN  = 1,
  parameter  int HP_MAX = 4,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clkSYS,
  input  logic                 n_reset,
  arbiter_mem_rr_if.slave      bus,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_data,
  input  logic                 mem_ack,
  input  logic [DW-1:0]        mem_rdata,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);
  import disp_pkg::*;

  localparam logic [0:0] ST_IDLE  = 1'(IDLE);
  localparam logic [0:0] ST_BUSY  = 1'(BUSY);
  localparam int         HW       = (HP_MAX > 0) ? $clog2(HP_MAX + 1) : 1;
  localparam logic [HW-1:0] HP_MAX_C = HW'(HP_MAX);

  logic [0:0]    state_reg;
  logic          mem_req_reg;
  logic          mem_wr_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_data_reg;
  logic [N-1:0]  grant_oh_reg;
  logic [IW-1:0] grant_id_reg;
  logic [HW-1:0] hp_cnt_reg;
  logic [HW-1:0] hp_cnt_next;

  logic          others;
  logic          hp_win;
  logic          any_req;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] winner;
  logic [N-1:0]  rr_req;

  generate
    if (N > 1) begin : g_others
      assign others = |bus.req[N-1:1];
    end else begin : g_single
      assign others = 1'b0;
    end
  endgenerate

  // Port 0 keeps winning until it has taken HP_MAX grants in a row over waiting ports.
  assign hp_win  = (HP_EN != 0) && bus.req[0] && ((hp_cnt_reg < HP_MAX_C) || !others);
  assign rr_req  = (HP_EN != 0) ? (bus.req & ~N'(1)) : bus.req;
  assign any_req = |bus.req;
  assign winner  = hp_win ? '0 : pick_idx;

  arbiter_rr_pick #(.N(N)) u_pick (
    .req   (rr_req),
    .last  (grant_id_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    hp_cnt_next = '0;
    if (winner == '0 && others) begin
      hp_cnt_next = (hp_cnt_reg == HP_MAX_C) ? hp_cnt_reg : hp_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_reg    <= ST_IDLE;
      mem_req_reg  <= 1'b0;
      mem_wr_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      grant_oh_reg <= '0;
      grant_id_reg <= IW'(N - 1);
      hp_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            state_reg    <= ST_BUSY;
            mem_req_reg  <= 1'b1;
            mem_wr_reg   <= bus.wr[winner];
            mem_addr_reg <= bus.addr[winner];
            mem_data_reg <= bus.data[winner];
            grant_oh_reg <= N'(1) << winner;
            grant_id_reg <= winner;
            if (HP_EN != 0) begin
              hp_cnt_reg <= hp_cnt_next;
            end
          end
        end
        default: begin
          // Requests are ignored while busy; only the memory accept moves us on.
          if (mem_ack) begin
            state_reg    <= ST_IDLE;
            mem_req_reg  <= 1'b0;
            grant_oh_reg <= '0;
          end
        end
      endcase
    end
  end

  assign bus.ack   = mem_ack ? grant_oh_reg : '0;
  assign bus.rdata = mem_rdata;
  assign mem_req   = mem_req_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_data  = mem_data_reg;
  assign grant_id  = grant_id_reg;
  assign busy      = (state_reg == ST_BUSY);

  logic unused_ok;
  assign unused_ok = pick_valid;

endmodule
